// File: rtl/cpu_mem_pkg.sv
// Shared types, encodings and helpers for the CPU memory-access sequencer.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_1 = 2'd0;
  localparam logic [1:0] SIZE_2 = 2'd1;
  localparam logic [1:0] SIZE_4 = 2'd2;

  localparam logic [1:0] WRAP_LIN  = 2'd0;
  localparam logic [1:0] WRAP_PAGE = 2'd1;
  localparam logic [1:0] WRAP_64K  = 2'd2;

  // Wide enough to count the 4 beats of a 32-bit request on an 8-bit bus.
  localparam int unsigned BEAT_W = 3;

  // Number of bus beats for a request size; narrow requests take one beat.
  function automatic logic [BEAT_W-1:0] beats_f(input logic [1:0] size,
                                                input int unsigned bus_w);
    int unsigned nbits;
    nbits = 32'd8 << size;
    if (nbits <= bus_w) return BEAT_W'(1);
    return BEAT_W'(nbits / bus_w);
  endfunction

  // Lane slice carried by a beat: big-endian puts the MS slice at the lowest address.
  function automatic logic [BEAT_W-1:0] lane_sel_f(input logic [BEAT_W-1:0] beat,
                                                   input logic [BEAT_W-1:0] beats,
                                                   input logic              big_endian);
    return big_endian ? BEAT_W'(beats - beat - BEAT_W'(1)) : beat;
  endfunction

  // Byte mask covering the valid bytes of a request size.
  function automatic logic [31:0] size_mask_f(input logic [1:0] size);
    case (size)
      SIZE_1:  return 32'h0000_00FF;
      SIZE_2:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mem_addr_step.sv
// Next beat address: add the step, keeping the bits above the wrap window fixed.
module cpu_mem_addr_step
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_step,
  input  logic [1:0]        i_wrap,
  output logic [ADDR_W-1:0] o_next_c
);

  localparam logic [ADDR_W-1:0] PAGE_M = ADDR_W'(32'h0000_00FF);
  localparam logic [ADDR_W-1:0] BANK_M = ADDR_W'(32'h0000_FFFF);

  logic [ADDR_W-1:0] sum_c;

  // Linear add, then splice the carry-free low window back onto the fixed high bits.
  always_comb begin
    sum_c    = i_addr + i_step;
    o_next_c = sum_c;
    case (i_wrap)
      WRAP_PAGE: o_next_c = (i_addr & ~PAGE_M) | (sum_c & PAGE_M);
      WRAP_64K:  o_next_c = (i_addr & ~BANK_M) | (sum_c & BANK_M);
      default:   o_next_c = sum_c;
    endcase
  end

endmodule

// File: rtl/cpu_mem_seq.sv
// Splits one 1/2/4-byte load or store into BUS_W-wide bus beats with wrap,
// endianness and per-beat ready timeout.
module cpu_mem_seq
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_W      = 32,
  parameter int unsigned BUS_W      = 8,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic [1:0]        i_req_wrap,
  input  logic [REG_W-1:0]  i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [REG_W-1:0]  o_rsp_rdata,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [BUS_W-1:0]  o_bus_data,
  input  logic [BUS_W-1:0]  i_bus_data,
  input  logic              i_bus_data_ready
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned STEP  = BUS_W / 8;
  localparam logic        BE    = (BIG_ENDIAN != 0);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          wrap_q, wrap_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic [REG_W-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [REG_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                bus_clk_q, bus_clk_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [BUS_W-1:0]    bus_data_q, bus_data_d;

  logic [ADDR_W-1:0]   next_addr_c;
  logic [BEAT_W-1:0]   lane_cur_c, lane_nxt_c;
  logic [BUS_W-1:0]    rd_mask_c;
  logic                legal_c;

  cpu_mem_addr_step #(
    .ADDR_W (ADDR_W)
  ) u_addr_step (
    .i_addr   (cur_addr_q),
    .i_step   (ADDR_W'(STEP)),
    .i_wrap   (wrap_q),
    .o_next_c (next_addr_c)
  );

  // Next-state, datapath and next-output computation; outputs follow the next state.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    wrap_d      = wrap_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    cur_addr_d  = cur_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    bus_clk_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    lane_cur_c  = lane_sel_f(beat_q, beats_q, BE);
    lane_nxt_c  = '0;
    rd_mask_c   = BUS_W'(size_mask_f(size_q));
    legal_c     = (i_req_size != 2'd3) && (i_req_wrap != 2'd3) &&
                  ((32'd8 << i_req_size) <= REG_W);

    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          we_d       = i_req_we;
          size_d     = i_req_size;
          wrap_d     = i_req_wrap;
          beats_d    = beats_f(i_req_size, BUS_W);
          beat_d     = '0;
          cur_addr_d = i_req_addr;
          wdata_d    = i_req_we ? (i_req_wdata & REG_W'(size_mask_f(i_req_size))) : '0;
          rdata_d    = '0;
          cnt_d      = '0;
          err_d      = !legal_c;
          state_d    = legal_c ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_bus_data_ready) begin
          if (!we_q) begin
            rdata_d = rdata_q |
                      (REG_W'(i_bus_data & rd_mask_c) << (int'(lane_cur_c) * BUS_W));
          end
          cur_addr_d = next_addr_c;
          beat_d     = beat_q + BEAT_W'(1);
          state_d    = ((beat_q + BEAT_W'(1)) == beats_q) ? ST_DONE : ST_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    lane_nxt_c  = lane_sel_f(beat_d, beats_d, BE);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_err_d   = rsp_valid_d && err_d;
    rsp_rdata_d = (rsp_valid_d && !err_d) ? rdata_d : '0;

    if (state_d == ST_ISSUE) begin
      bus_clk_d  = 1'b1;
      bus_we_d   = we_d;
      bus_addr_d = cur_addr_d;
      bus_data_d = BUS_W'(wdata_d >> (int'(lane_nxt_c) * BUS_W));
    end else if (state_d != ST_WAIT) begin
      bus_we_d   = 1'b0;
      bus_addr_d = '0;
      bus_data_d = '0;
    end
  end

  // State, request context and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      wrap_q      <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      cur_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_clk_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      wrap_q      <= wrap_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      cur_addr_q  <= cur_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_clk_q   <= bus_clk_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_bus_clk   = bus_clk_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_data  = bus_data_q;

endmodule
